frame_ram_arbiter: RTL and testbench

FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

---
 rtl/frame_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_frame_ram_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ram_arbiter.sv
// rtl/frame_ram_arbiter.sv - FIFO arbiter sharing one block-RAM port between capture writes and dump reads (optional FRAME_RAM_ARB_STATS_EN adds overflow_cnt)
module frame_ram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_ena,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
`ifdef FRAME_RAM_ARB_STATS_EN
  ,
  output logic [15:0]       overflow_cnt
`endif
);

  localparam logic [0:0] ST_ARB     = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [0:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              rr_rd_next;
  logic              wr_elig;
  logic              rd_elig;
  logic              contest;
  logic              wr_gnt;
  logic              rd_gnt;

  assign level = count;
  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // Grants are suppressed while rst is high so the RAM port stays idle during reset.
  assign wr_elig  = !rst && wr_valid && !full && !flush;
  assign rd_elig  = !rst && (state == ST_ARB) && !empty && !rd_valid && !flush;
  assign contest  = wr_elig && rd_elig;
  assign wr_gnt   = wr_elig && (!rd_elig || !rr_rd_next);
  assign rd_gnt   = rd_elig && (!wr_elig || rr_rd_next);
  assign wr_ready = wr_gnt;

  // Drive the shared RAM port from whichever requester won this cycle.
  always_comb begin
    ram_addr    = '0;
    ram_wr_ena  = 1'b0;
    ram_wr_data = '0;
    if (wr_gnt) begin
      ram_addr    = wr_ptr;
      ram_wr_ena  = 1'b1;
      ram_wr_data = wr_data;
    end else if (rd_gnt) begin
      ram_addr = rd_ptr;
    end
  end

  // Pointer and occupancy bookkeeping; a grant is exclusive so count moves by one at most.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (wr_gnt) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (rd_gnt) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

  // Round-robin turn only moves on contested cycles; flush never contests so it is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_rd_next <= 1'b0;
    end else if (contest) begin
      rr_rd_next <= wr_gnt;
    end
  end

  // Read pipeline: wait one cycle for the registered RAM output, then hold it until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ARB;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (flush) begin
      state    <= ST_ARB;
      rd_valid <= 1'b0;
    end else begin
      if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
      case (state)
        ST_ARB: begin
          if (rd_gnt) begin
            state <= ST_RD_WAIT;
          end
        end
        default: begin
          rd_data  <= ram_rd_data;
          rd_valid <= 1'b1;
          state    <= ST_ARB;
        end
      endcase
    end
  end

`ifdef FRAME_RAM_ARB_STATS_EN
  // Count cycles where the capture side was stalled by a full buffer, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_cnt <= '0;
    end else if (flush) begin
      overflow_cnt <= '0;
    end else if (wr_valid && full && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb/tb_frame_ram_arbiter.sv - randomized self-checking bench for frame_ram_arbiter with queue reference model
module tb_frame_ram_arbiter;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_wr_ena;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
`ifdef FRAME_RAM_ARB_STATS_EN
  logic [15:0]   overflow_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  frame_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .ram_addr(ram_addr), .ram_wr_ena(ram_wr_ena), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data),
    .level(level), .full(full), .empty(empty)
`ifdef FRAME_RAM_ARB_STATS_EN
    , .overflow_cnt(overflow_cnt)
`endif
  );

  // Block RAM with one-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_addr];
  end

  // Reference model: FIFO contents as a queue, RAM slots as modular indices.
  logic [DW-1:0] q[$];
  int            m_wp, m_rp, m_ovf;
  bit            m_rr, m_wait, m_rdv, m_gw, m_gr, m_contest, m_full;
  logic [DW-1:0] m_pend, m_rdd;
  logic [87:0]   exp_vec;

  task automatic model_reset();
    q.delete();
    m_wp = 0; m_rp = 0; m_ovf = 0;
    m_rr = 0; m_wait = 0; m_rdv = 0; m_rdd = '0; m_pend = '0;
  endtask

  task automatic model_eval();
    bit we, re;
    logic [AW-1:0] ea;
    m_full = (q.size() == DEPTH);
    we = wr_valid && !m_full && !flush;
    re = !m_wait && (q.size() > 0) && !m_rdv && !flush;
    m_contest = we && re;
    m_gw = we && (!re || !m_rr);
    m_gr = re && (!we || m_rr);
    ea = m_gw ? AW'(m_wp) : (m_gr ? AW'(m_rp) : '0);
    exp_vec = {m_gw, m_gw, ea, (m_gw ? wr_data : 32'h0), (AW+1)'(q.size()),
               m_full, (q.size() == 0), m_rdv, m_rdd};
  endtask

  task automatic model_update();
    if (flush) begin
      q.delete();
      m_wp = 0; m_rp = 0; m_wait = 0; m_rdv = 0; m_ovf = 0;
    end else begin
      if (wr_valid && m_full && m_ovf < 65535) m_ovf++;
      if (m_rdv && rd_ready) m_rdv = 0;
      if (m_wait) begin m_rdv = 1; m_rdd = m_pend; m_wait = 0; end
      if (m_contest) m_rr = m_gw;
      if (m_gw) begin q.push_back(wr_data); m_wp = (m_wp + 1) % DEPTH; end
      if (m_gr) begin m_pend = q.pop_front(); m_rp = (m_rp + 1) % DEPTH; m_wait = 1; end
    end
  endtask

  function automatic logic [87:0] pack_obs();
    return {wr_ready, ram_wr_ena, ram_addr, ram_wr_data, level, full, empty, rd_valid, rd_data};
  endfunction

  task automatic eval_cycle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1; wr_data = $urandom; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({wr_ready, ram_wr_ena, ram_addr, full, empty, level, rd_valid, rd_data} !==
          {1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 10'd0, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset_outputs i=%0d got wr_ready=%b wr_ena=%b addr=%0d full=%b empty=%b level=%0d rd_valid=%b rd_data=%h required 0,0,0,0,1,0,0,0",
                 i, wr_ready, ram_wr_ena, ram_addr, full, empty, level, rd_valid, rd_data);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    model_reset();
  endtask

  task automatic test_three_words();
    logic [DW-1:0] w [3];
    logic [DW-1:0] first_rd;
    int nw, t_gr, t_v;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    do_reset();
    nw = 0; t_gr = -1; t_v = -1; first_rd = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      wr_valid = (nw < 3);
      wr_data  = (nw < 3) ? w[nw % 3] : '0;
      eval_cycle();
      n_cmp++;
      if (pack_obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL three_words cyc=%0d got=%h required=%h", cyc, pack_obs(), exp_vec);
      end
      if (m_gw) begin
        n_cmp++;
        if (ram_addr !== AW'(nw) || ram_wr_ena !== 1'b1) begin
          n_fail++;
          $display("FAIL three_words_addr word=%0d got addr=%0d ena=%b required addr=%0d ena=1", nw, ram_addr, ram_wr_ena, nw);
        end
        nw++;
      end
      if (m_gr && t_gr < 0) t_gr = cyc;
      if (rd_valid === 1'b1 && t_v < 0) begin t_v = cyc; first_rd = rd_data; end
      end_cycle();
    end
    n_cmp++;
    if (t_gr < 0 || (t_v - t_gr) != 2) begin
      n_fail++;
      $display("FAIL three_words_latency got grant_cyc=%0d valid_cyc=%0d required valid 2 cycles after grant", t_gr, t_v);
    end
    n_cmp++;
    if (first_rd !== w[0] || rd_valid !== 1'b1 || rd_data !== w[0]) begin
      n_fail++;
      $display("FAIL three_words_rd_data got first=%h held=%h valid=%b required %h valid=1", first_rd, rd_data, rd_valid, w[0]);
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_fill_full();
    do_reset();
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int cyc = 0; cyc < 530; cyc++) begin
      wr_data = $urandom;
      eval_cycle();
      n_cmp++;
      if (pack_obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL fill cyc=%0d got=%h required=%h", cyc, pack_obs(), exp_vec);
      end
      end_cycle();
    end
    eval_cycle();
    n_cmp++;
    if (full !== 1'b1 || level !== 10'd512 || wr_ready !== 1'b0 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full got full=%b level=%0d wr_ready=%b empty=%b required 1,512,0,0", full, level, wr_ready, empty);
    end
`ifdef FRAME_RAM_ARB_STATS_EN
    n_cmp++;
    if (overflow_cnt !== 16'(m_ovf) || m_ovf == 0) begin
      n_fail++;
      $display("FAIL overflow_cnt got=%0d required=%0d", overflow_cnt, m_ovf);
    end
`endif
    end_cycle();
    wr_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    bit prev_win;
    do_reset();
    prev_win = 1'b0;
    wr_valid = 1'b1; rd_ready = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (q.size() >= 4) rd_ready = 1'b1;
      wr_data = $urandom;
      eval_cycle();
      n_cmp++;
      if (pack_obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL round_robin cyc=%0d got=%h required=%h", cyc, pack_obs(), exp_vec);
      end
      if (m_contest) begin
        n_cmp++;
        if (wr_ready !== !prev_win) begin
          n_fail++;
          $display("FAIL rr_alternate cyc=%0d got write_won=%b required %b", cyc, wr_ready, !prev_win);
        end
        prev_win = wr_ready;
      end
      end_cycle();
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int nw, dut_reads, cyc;
    do_reset();
    nw = 0; dut_reads = 0;
    for (cyc = 0; cyc < 6000 && dut_reads < 600; cyc++) begin
      wr_valid = (nw < 600);
      wr_data  = $urandom;
      rd_ready = ($urandom_range(0, 3) != 0);
      eval_cycle();
      n_cmp++;
      if (pack_obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL wrap cyc=%0d got=%h required=%h", cyc, pack_obs(), exp_vec);
      end
      if (m_gw) begin
        if (nw == 512) begin
          n_cmp++;
          if (ram_addr !== '0) begin
            n_fail++;
            $display("FAIL wrap_addr got=%0d required=0", ram_addr);
          end
        end
        nw++;
      end
      if (rd_valid === 1'b1 && rd_ready) dut_reads++;
      end_cycle();
    end
    n_cmp++;
    if (dut_reads != 600 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_count got reads=%0d empty=%b required 600,1", dut_reads, empty);
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_flush();
    int nw;
    bit seen_gr;
    do_reset();
    nw = 0; seen_gr = 0;
    for (int cyc = 0; cyc < 12 && !seen_gr; cyc++) begin
      wr_valid = (nw < 2);
      wr_data  = $urandom;
      eval_cycle();
      n_cmp++;
      if (pack_obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL flush_setup cyc=%0d got=%h required=%h", cyc, pack_obs(), exp_vec);
      end
      if (m_gw) nw++;
      seen_gr = m_gr;
      end_cycle();
    end
    n_cmp++;
    if (!seen_gr) begin
      n_fail++;
      $display("FAIL flush_grant_timeout got no read grant required one");
    end
    wr_valid = 1'b0; flush = 1'b1;
    eval_cycle();
    n_cmp++;
    if (pack_obs() !== exp_vec) begin
      n_fail++;
      $display("FAIL flush_cycle got=%h required=%h", pack_obs(), exp_vec);
    end
    end_cycle();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      n_cmp++;
      if (rd_valid !== 1'b0 || level !== 10'd0 || empty !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_after i=%0d got rd_valid=%b level=%0d empty=%b required 0,0,1", i, rd_valid, level, empty);
      end
      end_cycle();
    end
    wr_valid = 1'b1; wr_data = $urandom;
    eval_cycle();
    n_cmp++;
    if (wr_ready !== 1'b1 || ram_addr !== '0 || ram_wr_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_next_write got wr_ready=%b addr=%0d ena=%b required 1,0,1", wr_ready, ram_addr, ram_wr_ena);
    end
    end_cycle();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    bit seen_gr;
    do_reset();
    seen_gr = 0;
    for (int cyc = 0; cyc < 8 && !seen_gr; cyc++) begin
      wr_valid = (cyc == 0);
      wr_data  = $urandom;
      eval_cycle();
      seen_gr = m_gr;
      end_cycle();
    end
    wr_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rd_valid !== 1'b0 || !seen_gr) begin
        n_fail++;
        $display("FAIL reset_mid_read i=%0d got rd_valid=%b grant_seen=%b required 0,1", i, rd_valid, seen_gr);
      end
      @(posedge clk); #1;
    end
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_data  = $urandom;
      rd_ready = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      eval_cycle();
      n_cmp++;
      if (pack_obs() !== exp_vec) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h required=%h", cyc, pack_obs(), exp_vec);
      end
`ifdef FRAME_RAM_ARB_STATS_EN
      n_cmp++;
      if (overflow_cnt !== 16'(m_ovf)) begin
        n_fail++;
        $display("FAIL random_ovf cyc=%0d got=%0d required=%0d", cyc, overflow_cnt, m_ovf);
      end
`endif
      end_cycle();
    end
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_three_words();
    test_fill_full();
    test_round_robin();
    test_wrap();
    test_flush();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
